// File: rtl/rpsc_fault_reset_ctrl.sv
// Card 9 fault-latch reset controller: synchronizes fault and push-button inputs,
// records the first fault and sequences a guarded reset pulse to the card 9 latches.
module rpsc_fault_reset_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned PULSE_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fault_la,
    input  logic [7:0] fault_raw,
    input  logic       reset_btn,
    output logic       card9_reset,
    output logic       trip,
    output logic [7:0] first_fault,
    output logic       first_fault_valid,
    output logic       reset_busy,
    output logic       reset_denied
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PULSE,
        SETTLE,
        VERIFY
    } state_t;

    logic [7:0]      fault_la_m, fault_la_s;
    logic [7:0]      fault_raw_m, fault_raw_s;
    logic            btn_m, btn_s;
    logic            btn_db, btn_db_d;
    logic [DB_W-1:0] db_cnt;
    logic            btn_req;
    logic [7:0]      lowest_fault;
    state_t          state;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_la_m  <= '0;
            fault_la_s  <= '0;
            fault_raw_m <= '0;
            fault_raw_s <= '0;
            btn_m       <= 1'b0;
            btn_s       <= 1'b0;
        end else begin
            fault_la_m  <= fault_la;
            fault_la_s  <= fault_la_m;
            fault_raw_m <= fault_raw;
            fault_raw_s <= fault_raw_m;
            btn_m       <= reset_btn;
            btn_s       <= btn_m;
        end
    end

    // Button level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign btn_req      = btn_db & ~btn_db_d;
    assign lowest_fault = fault_la_s & (~fault_la_s + 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            trip <= 1'b0;
        end else begin
            trip <= |fault_la_s;
        end
    end

    // Reset parks the FSM in PULSE so release runs a full power-up sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= PULSE;
            cnt               <= '0;
            card9_reset       <= 1'b1;
            reset_busy        <= 1'b1;
            reset_denied      <= 1'b0;
            first_fault       <= '0;
            first_fault_valid <= 1'b0;
        end else begin
            reset_denied <= 1'b0;

            if (!first_fault_valid && (|fault_la_s) && (state != PULSE) && (state != SETTLE)) begin
                first_fault       <= lowest_fault;
                first_fault_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (btn_req) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (|fault_raw_s) begin
                        reset_denied <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        state       <= PULSE;
                        cnt         <= '0;
                        card9_reset <= 1'b1;
                        reset_busy  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        state       <= SETTLE;
                        cnt         <= '0;
                        card9_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state      <= VERIFY;
                        cnt        <= '0;
                        reset_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                VERIFY: begin
                    state <= IDLE;
                    if (fault_la_s == 8'h00) begin
                        first_fault       <= '0;
                        first_fault_valid <= 1'b0;
                    end else begin
                        reset_denied <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    card9_reset <= 1'b0;
                    reset_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rpsc_fault_reset_ctrl.md
RPSC_FAULT_RESET_CTRL -- requirements
Module: rpsc_fault_reset_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles needed to accept a reset_btn level change.
- PULSE_CYCLES, 16: width of the card9_reset pulse in clk cycles.
- SETTLE_CYCLES, 4: wait after the pulse before latch status is checked.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- fault_la  in  8  latched fault lines from card 9. Bit 0 is FF17 and bit 7 is FF24. Asynchronous to clk.
- fault_raw  in  8  raw fault inputs, same bit order as fault_la. Asynchronous to clk.
- reset_btn  in  1  operator reset push-button, active-high, bouncing, asynchronous.
- card9_reset  out  1  reset pulse driven to card 9 latches.
- trip  out  1  asserted while any synchronized fault_la bit is 1.
- first_fault  out  8  one-hot record of the first fault latched since the last successful reset.
- first_fault_valid  out  1  first_fault holds a capture.
- reset_busy  out  1  high in PULSE and SETTLE states.
- reset_denied  out  1  one-cycle pulse when a reset request is refused or fails.

Function
REQ-003 fault_la, fault_raw and reset_btn SHALL each pass through a 2-flop synchronizer before any use. All latencies below are measured from the synchronized value.
REQ-004 Debounce SHALL work as follows.
- A counter increments while synced reset_btn differs from btn_db, and clears to 0 when they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1, btn_db takes the new value and the counter clears.
REQ-005 A rising edge of btn_db SHALL generate a one-cycle reset request. The request is accepted only in IDLE; it is dropped in any other state.
REQ-006 trip SHALL equal the OR of synced fault_la, registered, giving 1 cycle of latency.
REQ-007 First-fault capture SHALL work as follows.
- When first_fault_valid=0 and synced fault_la is nonzero, first_fault takes the lowest-index set bit and first_fault_valid sets on the next cycle.
- If several bits rise in the same cycle, the lowest index wins.
- Later faults SHALL NOT alter first_fault.
REQ-008 The FSM SHALL have exactly these states: IDLE, CHECK, PULSE, SETTLE, VERIFY.
REQ-009 IDLE to CHECK SHALL occur on an accepted reset request.
REQ-010 CHECK behaviour:
- If synced fault_raw is nonzero, pulse reset_denied for 1 cycle and return to IDLE.
- Otherwise go to PULSE.
- CHECK lasts exactly 1 cycle.
REQ-011 PULSE behaviour: card9_reset=1 for exactly PULSE_CYCLES cycles, then go to SETTLE.
REQ-012 SETTLE behaviour: card9_reset=0 for exactly SETTLE_CYCLES cycles, then go to VERIFY.
REQ-013 VERIFY behaviour (1 cycle):
- If synced fault_la is 0, clear first_fault and first_fault_valid, then go to IDLE.
- Otherwise pulse reset_denied, keep first_fault, and go to IDLE.
REQ-014 During PULSE and SETTLE, first-fault capture SHALL be suppressed. Capture resumes from VERIFY onward.
REQ-015 card9_reset SHALL be registered, glitch-free, and high only in PULSE.
REQ-016 A single pulse/settle counter SHALL be used. It is sized by clog2 of the larger of PULSE_CYCLES and SETTLE_CYCLES, and SHALL NOT wrap.
REQ-017 A fault_raw assertion during PULSE or SETTLE SHALL NOT abort the sequence. VERIFY decides the outcome.

Reset
REQ-018 While reset=1, the block SHALL hold the following values.
- FSM state = PULSE and pulse counter = 0.
- card9_reset=1, reset_busy=1.
- trip=0, reset_denied=0.
- first_fault=8'h00, first_fault_valid=0.
- btn_db=0, debounce counter=0, all synchronizers=0.
REQ-019 After reset deasserts, the FSM SHALL complete a power-up sequence before reaching IDLE.
- card9_reset stays high for PULSE_CYCLES cycles counted from the first cycle with reset=0.
- The FSM then runs SETTLE and VERIFY as normal.
REQ-020 Reset asserted mid-sequence SHALL restart at REQ-018 values. No reset_denied pulse is issued.

Verification
REQ-021 Power-up: hold reset for 5 cycles, then release.
- Required: card9_reset high for exactly 16 cycles after release.
- Required: FSM in IDLE 4+1 cycles later; reset_denied stays 0.
REQ-022 Bounce filter:
- Toggle reset_btn every 200 cycles for 2000 cycles -> no request.
- Then hold reset_btn=1 for 1002 cycles -> exactly one 16-cycle card9_reset pulse.
REQ-023 Simultaneous faults: set fault_la=8'b0010_1000 in one cycle.
- Required: first_fault=8'h08, first_fault_valid=1, trip=1.
- Setting fault_la bit 0 later SHALL leave first_fault unchanged.
REQ-024 Raw fault still active: fault_raw=8'h04, then a debounced press.
- Required: reset_denied is a 1-cycle pulse.
- Required: no card9_reset; first_fault is unchanged.
REQ-025 Successful clear: fault_raw=0, with the model dropping fault_la during the card9_reset pulse.
- Required: trip=0 and first_fault=0 after VERIFY.
- Repeat with fault_la stuck at 8'h80: reset_denied pulses once and first_fault is kept.
REQ-026 Mid-operation reset: assert reset during SETTLE.
- Required: REQ-018 values on the next cycle.
- Required: a new full 16-cycle power-up pulse after release.
